// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one combinational 32-bit ALU between
// NUM_REQ requesters, with registered operands and a registered result.

package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op;
endpackage

module alu (
  input  alu_pkg::alu_op op_i,
  input  logic [31:0]    a_i,
  input  logic [31:0]    b_i,
  output logic [31:0]    result_o
);
  always_comb begin
    result_o = 32'd0;
    case (op_i)
      alu_pkg::ALU_ADD:  result_o = a_i + b_i;
      alu_pkg::ALU_SUB:  result_o = a_i - b_i;
      alu_pkg::ALU_AND:  result_o = a_i & b_i;
      alu_pkg::ALU_OR:   result_o = a_i | b_i;
      alu_pkg::ALU_XOR:  result_o = a_i ^ b_i;
      alu_pkg::ALU_SLL:  result_o = a_i << b_i[4:0];
      alu_pkg::ALU_SRL:  result_o = a_i >> b_i[4:0];
      alu_pkg::ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      alu_pkg::ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      alu_pkg::ALU_SLTU: result_o = {31'd0, a_i < b_i};
      default:           result_o = 32'd0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  alu_pkg::alu_op [NUM_REQ-1:0]        req_op_i,
  input  logic [NUM_REQ-1:0][31:0]            req_a_i,
  input  logic [NUM_REQ-1:0][31:0]            req_b_i,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  input  logic [NUM_REQ-1:0]                  rsp_ready_i,
  output logic [31:0]                         rsp_result_o,
  output logic                                busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q;
  logic [IDX_W-1:0] ptr_q, id_q, grant_idx;
  logic           grant_valid;
  alu_pkg::alu_op op_q;
  logic [31:0]    a_q, b_q, result_q, alu_result;

  alu u_alu (
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .result_o(alu_result)
  );

  // Scan from the farthest offset down so the requester closest to ptr_q wins.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (req_valid_i[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

  // Ready is gated by reset so nothing looks accepted while reset is held.
  always_comb begin
    req_ready_o = '0;
    if (rst_ni && state_q == IDLE && grant_valid)
      req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid_o  = '0;
    rsp_result_o = 32'd0;
    if (state_q == RESP) begin
      rsp_valid_o[id_q] = 1'b1;
      rsp_result_o      = result_q;
    end
  end

  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      op_q     <= alu_pkg::ALU_ADD;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            op_q    <= req_op_i[grant_idx];
            a_q     <= req_a_i[grant_idx];
            b_q     <= req_b_i[grant_idx];
            id_q    <= grant_idx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_result;
          state_q  <= RESP;
        end
        RESP: begin
          if (rsp_ready_i[id_q]) begin
            state_q <= IDLE;
            ptr_q   <= (id_q == IDX_W'(NUM_REQ - 1)) ? '0 : id_q + IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with two requesters.

module tb_alu_arbiter;

  logic                         clk_i;
  logic                         rst_ni;
  logic [1:0]                   req_valid;
  logic [1:0]                   req_ready_o;
  alu_pkg::alu_op [1:0]         req_op;
  logic [1:0][31:0]             req_a;
  logic [1:0][31:0]             req_b;
  logic [1:0]                   rsp_valid_o;
  logic [1:0]                   rsp_ready;
  logic [31:0]                  rsp_result_o;
  logic                         busy_o;

  int check_count = 0;
  int error_count = 0;

  alu_arbiter #(.NUM_REQ(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready),
    .rsp_result_o(rsp_result_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni    = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Issues one request on requester r and waits (bounded) for its response.
  task automatic run_single(input int r, input alu_pkg::alu_op op, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] res, output logic ok);
    int n;
    ok  = 1'b0;
    res = '0;
    @(negedge clk_i);
    req_valid[r] = 1'b1;
    req_op[r]    = op;
    req_a[r]     = a;
    req_b[r]     = b;
    rsp_ready    = '1;
    #1;
    n = 0;
    while (!req_ready_o[r] && n < 10) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (!req_ready_o[r]) begin
      req_valid[r] = 1'b0;
      return;
    end
    @(negedge clk_i);
    req_valid[r] = 1'b0;
    #1;
    n = 0;
    while (!rsp_valid_o[r] && n < 10) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (rsp_valid_o[r]) begin
      res = rsp_result_o;
      ok  = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_ni    = 1'b0;
    req_valid = '0;
    req_op    = '{alu_pkg::ALU_ADD, alu_pkg::ALU_ADD};
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;
    repeat (3) @(negedge clk_i);
    #1;
    check_count++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 2'b00 || rsp_result_o !== 32'd0 || req_ready_o !== 2'b00) begin
      error_count++;
      $display("[TB] FAIL reset_outputs busy=%b rsp_valid=%b result=%h ready=%b required 0/00/0/00",
               busy_o, rsp_valid_o, rsp_result_o, req_ready_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_add_latency();
    req_valid = 2'b01;
    req_op[0] = alu_pkg::ALU_ADD;
    req_a[0]  = 32'd5;
    req_b[0]  = 32'd7;
    rsp_ready = 2'b11;
    #1;
    check_count++;
    if (req_ready_o !== 2'b01 || busy_o !== 1'b0) begin
      error_count++;
      $display("[TB] FAIL add_accept ready=%b busy=%b required 01/0", req_ready_o, busy_o);
    end
    @(negedge clk_i);
    req_valid = 2'b00;
    #1;
    check_count++;
    if (busy_o !== 1'b1 || rsp_valid_o !== 2'b00 || req_ready_o !== 2'b00) begin
      error_count++;
      $display("[TB] FAIL add_exec busy=%b rsp_valid=%b ready=%b required 1/00/00", busy_o, rsp_valid_o, req_ready_o);
    end
    @(negedge clk_i);
    #1;
    check_count++;
    if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd12 || busy_o !== 1'b1) begin
      error_count++;
      $display("[TB] FAIL add_resp rsp_valid=%b result=%h busy=%b required 01/0000000c/1",
               rsp_valid_o, rsp_result_o, busy_o);
    end
    @(negedge clk_i);
    #1;
    check_count++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 2'b00 || rsp_result_o !== 32'd0) begin
      error_count++;
      $display("[TB] FAIL add_idle busy=%b rsp_valid=%b result=%h required 0/00/0", busy_o, rsp_valid_o, rsp_result_o);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_valid = 2'b11;
    req_op[0] = alu_pkg::ALU_SUB;
    req_a[0]  = 32'd3;
    req_b[0]  = 32'd5;
    req_op[1] = alu_pkg::ALU_SLL;
    req_a[1]  = 32'd1;
    req_b[1]  = 32'h24;
    #1;
    check_count++;
    if (req_ready_o !== 2'b01) begin
      error_count++;
      $display("[TB] FAIL simul_first_grant ready=%b required 01", req_ready_o);
    end
    @(negedge clk_i);
    req_valid = 2'b10;
    @(negedge clk_i);
    #1;
    check_count++;
    if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'hFFFF_FFFE) begin
      error_count++;
      $display("[TB] FAIL simul_sub rsp_valid=%b result=%h required 01/fffffffe", rsp_valid_o, rsp_result_o);
    end
    @(negedge clk_i);
    #1;
    check_count++;
    if (req_ready_o !== 2'b10) begin
      error_count++;
      $display("[TB] FAIL simul_second_grant ready=%b required 10", req_ready_o);
    end
    @(negedge clk_i);
    req_valid = 2'b00;
    @(negedge clk_i);
    #1;
    check_count++;
    if (rsp_valid_o !== 2'b10 || rsp_result_o !== 32'h10) begin
      error_count++;
      $display("[TB] FAIL simul_sll rsp_valid=%b result=%h required 10/00000010", rsp_valid_o, rsp_result_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_fairness();
    int order[6];
    int grants;
    int cyc;
    req_valid = 2'b11;
    req_op[0] = alu_pkg::ALU_ADD;
    req_op[1] = alu_pkg::ALU_ADD;
    rsp_ready = 2'b11;
    grants = 0;
    cyc = 0;
    while (grants < 6 && cyc < 60) begin
      #1;
      if (req_ready_o == 2'b01) begin
        order[grants] = 0;
        grants++;
      end else if (req_ready_o == 2'b10) begin
        order[grants] = 1;
        grants++;
      end
      @(negedge clk_i);
      cyc++;
    end
    req_valid = 2'b00;
    check_count++;
    if (grants != 6) begin
      error_count++;
      $display("[TB] FAIL fair_grant_count got=%0d required 6", grants);
    end
    for (int i = 0; i < grants; i++) begin
      check_count++;
      if (order[i] != i % 2) begin
        error_count++;
        $display("[TB] FAIL fair_order[%0d] got=%0d required %0d", i, order[i], i % 2);
      end
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_compare_shift();
    logic [31:0] res;
    logic ok;
    run_single(1, alu_pkg::ALU_SLTU, 32'hFFFF_FFFF, 32'd1, res, ok);
    check_count++;
    if (!ok || res !== 32'd0) begin
      error_count++;
      $display("[TB] FAIL sltu ok=%b result=%h required 00000000", ok, res);
    end
    run_single(1, alu_pkg::ALU_SLT, 32'hFFFF_FFFF, 32'd1, res, ok);
    check_count++;
    if (!ok || res !== 32'd1) begin
      error_count++;
      $display("[TB] FAIL slt ok=%b result=%h required 00000001", ok, res);
    end
    run_single(1, alu_pkg::ALU_SRA, 32'h8000_0000, 32'd31, res, ok);
    check_count++;
    if (!ok || res !== 32'hFFFF_FFFF) begin
      error_count++;
      $display("[TB] FAIL sra ok=%b result=%h required ffffffff", ok, res);
    end
    run_single(0, alu_pkg::ALU_ADD, 32'hFFFF_FFFF, 32'd1, res, ok);
    check_count++;
    if (!ok || res !== 32'd0) begin
      error_count++;
      $display("[TB] FAIL add_wrap ok=%b result=%h required 00000000", ok, res);
    end
    run_single(0, alu_pkg::ALU_SRL, 32'h8000_0000, 32'h0000_0124, res, ok);
    check_count++;
    if (!ok || res !== 32'h0800_0000) begin
      error_count++;
      $display("[TB] FAIL srl_low5 ok=%b result=%h required 08000000", ok, res);
    end
    run_single(1, alu_pkg::alu_op'(4'd15), 32'h1234_5678, 32'h9ABC_DEF0, res, ok);
    check_count++;
    if (!ok || res !== 32'd0) begin
      error_count++;
      $display("[TB] FAIL unlisted_op ok=%b result=%h required 00000000", ok, res);
    end
    @(negedge clk_i);
  endtask

  task automatic test_backpressure();
    req_valid = 2'b01;
    req_op[0] = alu_pkg::ALU_ADD;
    req_a[0]  = 32'd10;
    req_b[0]  = 32'd20;
    rsp_ready = 2'b10;
    #1;
    check_count++;
    if (req_ready_o !== 2'b01) begin
      error_count++;
      $display("[TB] FAIL bp_accept ready=%b required 01", req_ready_o);
    end
    @(negedge clk_i);
    req_valid = 2'b10;
    req_op[1] = alu_pkg::ALU_SUB;
    req_a[1]  = 32'd100;
    req_b[1]  = 32'd1;
    @(negedge clk_i);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) rsp_ready = 2'b11;
      #1;
      check_count++;
      if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd30 || req_ready_o !== 2'b00) begin
        error_count++;
        $display("[TB] FAIL bp_hold[%0d] rsp_valid=%b result=%h ready=%b required 01/0000001e/00",
                 c, rsp_valid_o, rsp_result_o, req_ready_o);
      end
      @(negedge clk_i);
    end
    #1;
    check_count++;
    if (req_ready_o !== 2'b10) begin
      error_count++;
      $display("[TB] FAIL bp_next_grant ready=%b required 10", req_ready_o);
    end
    @(negedge clk_i);
    req_valid = 2'b00;
    @(negedge clk_i);
    #1;
    check_count++;
    if (rsp_valid_o !== 2'b10 || rsp_result_o !== 32'd99) begin
      error_count++;
      $display("[TB] FAIL bp_second_result rsp_valid=%b result=%h required 10/00000063", rsp_valid_o, rsp_result_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_exec();
    logic [31:0] res;
    logic ok;
    // Complete a req0 op so the pointer favours req1, then reset during req1's EXEC.
    run_single(0, alu_pkg::ALU_OR, 32'hF0, 32'h0F, res, ok);
    check_count++;
    if (!ok || res !== 32'hFF) begin
      error_count++;
      $display("[TB] FAIL pre_reset_or ok=%b result=%h required 000000ff", ok, res);
    end
    @(negedge clk_i);
    req_valid = 2'b10;
    req_op[1] = alu_pkg::ALU_XOR;
    req_a[1]  = 32'hAAAA_AAAA;
    req_b[1]  = 32'hFFFF_FFFF;
    @(negedge clk_i);
    req_valid = 2'b00;
    #1;
    rst_ni = 1'b0;
    req_valid = 2'b11;
    #1;
    check_count++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 2'b00 || rsp_result_o !== 32'd0 || req_ready_o !== 2'b00) begin
      error_count++;
      $display("[TB] FAIL mid_exec_reset busy=%b rsp_valid=%b result=%h ready=%b required 0/00/0/00",
               busy_o, rsp_valid_o, rsp_result_o, req_ready_o);
    end
    req_valid = 2'b00;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      #1;
      check_count++;
      if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin
        error_count++;
        $display("[TB] FAIL no_stale_rsp rsp_valid=%b busy=%b required 00/0", rsp_valid_o, busy_o);
      end
    end
    @(negedge clk_i);
    req_valid = 2'b11;
    req_op[0] = alu_pkg::ALU_AND;
    req_a[0]  = 32'hFF00_FF00;
    req_b[0]  = 32'h0FF0_0FF0;
    #1;
    check_count++;
    if (req_ready_o !== 2'b01) begin
      error_count++;
      $display("[TB] FAIL post_reset_ptr ready=%b required 01", req_ready_o);
    end
    @(negedge clk_i);
    req_valid = 2'b00;
    @(negedge clk_i);
    #1;
    check_count++;
    if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'h0F00_0F00) begin
      error_count++;
      $display("[TB] FAIL post_reset_and rsp_valid=%b result=%h required 01/0f000f00", rsp_valid_o, rsp_result_o);
    end
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_simultaneous();
    test_fairness();
    test_compare_shift();
    test_backpressure();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
